// File: rtl/serial_deser_logic.sv
// serial_deser_logic: serial-to-parallel deserializer with sync-pattern framing and valid/ready output
// tmrg default triplicate
module serial_deser_logic #(
   parameter int WIDTH = 8,
   parameter logic [WIDTH-1:0] SYNC = WIDTH'(8'hA5),
   parameter int FRAME_BYTES = 4
) (
   input  logic             c,
   input  logic             rstn,
   input  logic             din,
   input  logic             din_en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             dout_last,
   output logic             sync_det,
   output logic             overflow
);
   localparam int BW = $clog2(WIDTH);
   typedef enum logic {HUNT, LOCKED} state_t;
   state_t state, stateNext;
   logic [WIDTH-1:0] sr, srNext;
   logic [BW-1:0] bitCnt;
   logic [7:0] wordCnt;
   logic syncHit, loadWord, lastWord;

   // state register
   always_ff @(posedge c or negedge rstn)
      if (!rstn) state <= HUNT;
      else state <= stateNext;

   // lock on sync while hunting, drop back to hunting once the final word of the frame loads
   always_comb
      stateNext = syncHit ? LOCKED : (loadWord && lastWord) ? HUNT : state;

   // per-edge events derived from state, counters and the incoming bit
   always_comb begin
      srNext = {sr[WIDTH-2:0], din};
      syncHit = state == HUNT && din_en && srNext == SYNC;
      loadWord = state == LOCKED && din_en && bitCnt == BW'(WIDTH-1);
      lastWord = wordCnt == 8'(FRAME_BYTES-1);
   end

   // shift register, counters, output word and handshake; a load always wins over an accept
   always_ff @(posedge c or negedge rstn)
      if (!rstn) begin
         sr <= '0;
         bitCnt <= '0;
         wordCnt <= '0;
         dout <= '0;
         dout_valid <= 1'b0;
         dout_last <= 1'b0;
         sync_det <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (din_en) sr <= (loadWord && lastWord) ? '0 : srNext;
         sync_det <= syncHit;
         if (syncHit) begin
            bitCnt <= '0;
            wordCnt <= '0;
         end else if (state == LOCKED && din_en) begin
            bitCnt <= loadWord ? '0 : bitCnt + BW'(1);
            if (loadWord) wordCnt <= wordCnt + 8'd1;
         end
         if (loadWord) begin
            dout <= srNext;
            dout_last <= lastWord;
            dout_valid <= 1'b1;
            if (dout_valid && !dout_ready) overflow <= 1'b1;
         end else if (dout_valid && dout_ready) dout_valid <= 1'b0;
      end
endmodule

// File: tb/tb_serial_deser_logic.sv
// tb_serial_deser_logic: directed and randomized checks of serial_deser_logic against a frame-level model
module tb_serial_deser_logic;
   logic c = 1'b0, rstn = 1'b0, din = 1'b0, din_en = 1'b0, dout_ready = 1'b0;
   logic [7:0] dout;
   logic dout_valid, dout_last, sync_det, overflow;
   int vecs = 0, errs = 0, syncCnt = 0;
   bit mHunt, mValid, mLast, mSync, mOvf;
   int mWin, mWrd, mNb, mWc;
   logic [7:0] mData;
   logic [7:0] got[$];

   serial_deser_logic dut (
      .c(c), .rstn(rstn), .din(din), .din_en(din_en), .dout(dout), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .dout_last(dout_last), .sync_det(sync_det), .overflow(overflow)
   );

   always #5 c = ~c;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mHunt = 1; mWin = 0; mWrd = 0; mNb = 0; mWc = 0;
      mData = 0; mValid = 0; mLast = 0; mSync = 0; mOvf = 0;
   endtask

   // frame-level reference: hunt for the last 8 bits matching A5, then collect 4 bytes MSB-first
   task automatic modelEdge(bit b, bit en, bit rdy);
      bit loaded = 0;
      mSync = 0;
      if (en) begin
         if (mHunt) begin
            mWin = ((mWin << 1) | int'(b)) % 256;
            if (mWin == 'hA5) begin
               mHunt = 0; mNb = 0; mWc = 0; mWrd = 0; mSync = 1;
            end
         end else begin
            mWrd = ((mWrd << 1) | int'(b)) % 256;
            mNb++;
            if (mNb == 8) begin
               if (mValid && !rdy) mOvf = 1;
               mData = 8'(mWrd);
               mLast = (mWc == 3);
               mValid = 1;
               loaded = 1;
               mNb = 0;
               mWc++;
               if (mWc == 4) begin
                  mHunt = 1; mWin = 0;
               end
            end
         end
      end
      if (!loaded && mValid && rdy) mValid = 0;
   endtask

   task automatic step(bit b, bit en, bit rdy);
      din = b; din_en = en; dout_ready = rdy;
      @(posedge c);
      if (dout_valid && rdy) got.push_back(dout);
      modelEdge(b, en, rdy);
      #1;
      if (sync_det) syncCnt++;
      chk("valid", dout_valid, mValid);
      chk("dout", dout, mData);
      chk("last", dout_last, mLast);
      chk("sync_det", sync_det, mSync);
      chk("overflow", overflow, mOvf);
   endtask

   // gap: 0 none, 1 idle before every bit, 2 random idles; rdyMode: 0 low, 1 high, 2 random
   task automatic sendByte(logic [7:0] v, int gap, int rdyMode);
      for (int i = 7; i >= 0; i--) begin
         if (gap == 1) step(bit'($urandom_range(1)), 0, rdyMode == 2 ? bit'($urandom_range(1)) : bit'(rdyMode));
         while (gap == 2 && $urandom_range(3) == 0)
            step(bit'($urandom_range(1)), 0, rdyMode == 2 ? bit'($urandom_range(1)) : bit'(rdyMode));
         step(v[i], 1, rdyMode == 2 ? bit'($urandom_range(1)) : bit'(rdyMode));
      end
   endtask

   task automatic doReset();
      rstn = 0;
      #1;
      modelReset();
      chk("rst_valid", dout_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_last", dout_last, 0);
      chk("rst_sync", sync_det, 0);
      chk("rst_ovf", overflow, 0);
      @(posedge c);
      #1;
      rstn = 1;
   endtask

   task automatic checkFrame(string tag);
      logic [7:0] exp [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
      chk({tag, "_count"}, got.size(), 4);
      for (int i = 0; i < 4 && i < got.size(); i++) chk({tag, "_word"}, got[i], exp[i]);
      chk({tag, "_syncs"}, syncCnt, 1);
   endtask

   initial begin
      logic [7:0] pay [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
      modelReset();
      repeat (2) @(posedge c);
      #1;
      doReset();
      // basic frame, enable and ready always high
      got.delete(); syncCnt = 0;
      sendByte(8'hA5, 0, 1);
      for (int i = 0; i < 4; i++) sendByte(pay[i], 0, 1);
      repeat (3) step(0, 0, 1);
      checkFrame("basic");
      // same frame with enable low every other cycle
      got.delete(); syncCnt = 0;
      sendByte(8'hA5, 1, 1);
      for (int i = 0; i < 4; i++) sendByte(pay[i], 1, 1);
      repeat (3) step(0, 0, 1);
      checkFrame("stretch");
      // sync offset by one leading bit
      got.delete(); syncCnt = 0;
      step(0, 1, 1);
      sendByte(8'hA5, 0, 1);
      for (int i = 0; i < 4; i++) sendByte(pay[i], 0, 1);
      repeat (2) step(0, 0, 1);
      checkFrame("offset");
      // consumer stalled for the whole frame
      sendByte(8'hA5, 0, 0);
      for (int i = 0; i < 4; i++) sendByte(pay[i], 0, 0);
      chk("stall_ovf", overflow, 1);
      chk("stall_dout", dout, 8'h78);
      chk("stall_last", dout_last, 1);
      chk("stall_valid", dout_valid, 1);
      step(0, 0, 1);
      doReset();
      // accept on the same edge a new word loads
      sendByte(8'hA5, 0, 1);
      sendByte(8'h12, 0, 0);
      for (int i = 7; i >= 1; i--) step(pay[1][i], 1, 0);
      step(pay[1][0], 1, 1);
      chk("same_valid", dout_valid, 1);
      chk("same_dout", dout, 8'h34);
      chk("same_ovf", overflow, 0);
      sendByte(8'h56, 0, 1);
      sendByte(8'h78, 0, 1);
      // reset mid-word, then payload without sync
      sendByte(8'hA5, 0, 1);
      for (int i = 7; i >= 3; i--) step(pay[0][i], 1, 1);
      doReset();
      for (int i = 0; i < 4; i++) sendByte(pay[i], 0, 1);
      chk("nosync_valid", dout_valid, 0);
      // randomized frames, noise, stalls and occasional resets
      for (int n = 0; n < 60; n++) begin
         int k = $urandom_range(12);
         for (int i = 0; i < k; i++) step(bit'($urandom_range(1)), bit'($urandom_range(1)), bit'($urandom_range(1)));
         sendByte(8'hA5, 2, 2);
         for (int i = 0; i < 4; i++) sendByte(8'($urandom), 2, 2);
         if ($urandom_range(9) == 0) doReset();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
